sdr_read_data_path: RTL and testbench
=====================================

# sdr_read_data_path

Read-side data path of the SDRAM controller: captures read data from the SDRAM DQ bus at the programmed CAS latency and marks each beat of the burst. Beats are buffered in a small first-word-fall-through FIFO and handed to the host with a valid/ready handshake. It sits between the SDRAM DQ input pins and the host read port. The command path drives it with one start pulse per READ command.

## Interface
Parameters:
- DATA_WIDTH, 32: SDRAM/host data width.
- FIFO_DEPTH, 8: read FIFO entries. Must be a power of 2 and ≥ 2.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RESET_N  in  1  reset. Asynchronous assertion, active-low.
- RD_START  in  1  one-cycle pulse in the cycle the READ command is driven to the SDRAM.
- CAS_LAT  in  2  CAS latency. Legal values are 2 and 3. Quasi-static: change it only while BUSY=0.
- BURST_LEN  in  2  burst-length code: 0=1, 1=2, 2=4, 3=8 beats. Sampled with RD_START.
- DQIN  in  DATA_WIDTH  SDRAM DQ input.
- DOUT  out  DATA_WIDTH  FIFO head data.
- DOUT_VALID  out  1  FIFO non-empty.
- DOUT_READY  in  1  host accepts the head when DOUT_VALID=1.
- RD_DONE  out  1  one-cycle pulse, registered after the last beat of a burst is captured.
- BUSY  out  1  a burst is pending or capturing.
- ERR_OVERLAP  out  1  one-cycle pulse when an illegal RD_START is dropped.
- OVERFLOW  out  1  sticky flag: a captured beat was lost because the FIFO was full.
- FIFO_LEVEL  out  log2(FIFO_DEPTH)+1  current number of FIFO entries.

## Operation
- **Latency tracker.** A 3-stage token shift register.
  - RD_START inserts a token together with the decoded beat count.
  - The tap selected by CAS_LAT loads the beat counter and begins capture.
- **Capture.**
  - While the beat counter is nonzero, DQIN is written into the FIFO on every edge and the counter decrements.
  - When the counter reaches 0, RD_DONE pulses on the following cycle.
- **Start spacing.**
  - An RD_START is legal when it comes ≥ BL cycles after the previous accepted RD_START. Back-to-back bursts therefore stream with no gap beats.
  - An earlier RD_START is ignored and ERR_OVERLAP pulses.
- **BUSY** is high from the edge that samples an accepted RD_START until the edge that captures the last beat.
- **FIFO.** FWFT, with pointer widths log2(FIFO_DEPTH)+1.
  - Pop happens on an edge where DOUT_VALID & DOUT_READY.
  - Write when full without a simultaneous pop: the beat is dropped and OVERFLOW sets. OVERFLOW clears only on reset.
  - Write when full with a simultaneous pop: the write succeeds and the level is unchanged.
  - Write to an empty FIFO: DOUT_VALID rises after that same edge. There is no combinational bypass from DQIN.
- **Reset mid-burst.** The token register, beat counter and FIFO clear immediately. Remaining beats on DQIN are ignored.

## Timing
- RD_START is sampled at edge E0. Beat k (k=0..BL-1) is sampled from DQIN at edge E0+CAS_LAT+k.
- DOUT_VALID is high after edge E0+CAS_LAT, provided the FIFO was empty.
- RD_DONE is high during the cycle after edge E0+CAS_LAT+BL-1.
- Reset values: DOUT=0, DOUT_VALID=0, RD_DONE=0, BUSY=0, ERR_OVERLAP=0, OVERFLOW=0, FIFO_LEVEL=0.
- Host throughput is one beat per cycle when DOUT_READY is held high.

## Configuration
- SDR_RD_REG_IN_EN
  - Defined: DQIN passes through one input register, reset to 0, before capture. All capture edges shift by +1 (beat k at E0+CAS_LAT+1+k), and RD_DONE and DOUT_VALID shift with them.
  - Undefined: DQIN is sampled directly, with timing exactly as above.
  - Start-spacing and FIFO rules are identical in both builds.

## Test plan
- **CL=2, BL=4:** CAS_LAT=2, BURST_LEN=2, RD_START at E0, DQIN=0x11,0x22,0x33,0x44 at E2..E5, DOUT_READY=1 → DOUT sequence 0x11..0x44 with DOUT_VALID high 4 cycles from after E2, RD_DONE once after E5, BUSY low after E5.
- **CL=3 back-to-back:** CAS_LAT=3, BL=2 bursts started at E0 and E2 → 4 contiguous beats captured at E3..E6, two RD_DONE pulses, ERR_OVERLAP never set.
- **Overlap:** BL=8 started at E0, second RD_START at E3 → ERR_OVERLAP pulses after E3, exactly 8 beats captured, one RD_DONE.
- **Overflow and full:** FIFO_DEPTH=8, DOUT_READY=0, two BL=8 bursts → FIFO_LEVEL=8, OVERFLOW=1 after the 9th beat edge, first 8 values retained in order. Then DOUT_READY=1 with a further burst: writes succeed while popping at full.
- **Reset mid-burst:** RESET_N low at E0+CAS_LAT+2 of a BL=8 burst → all outputs 0 immediately. After release, no further beats are captured and FIFO_LEVEL stays 0.
- **SDR_RD_REG_IN_EN build:** rerun the CL=2, BL=4 case → beats are taken from the DQIN values presented at E2..E5 but enter the FIFO one edge later (E3..E6), and RD_DONE comes one cycle later.

Source files
------------

// File: rtl/sdr_read_data_path_if.sv
// Host read port bundle: FWFT FIFO head with valid/ready.
// master = data path side, slave = host side.
interface sdr_read_data_path_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] DOUT;
  logic                  DOUT_VALID;
  logic                  DOUT_READY;

  modport master (
    output DOUT,
    output DOUT_VALID,
    input  DOUT_READY
  );

  modport slave (
    input  DOUT,
    input  DOUT_VALID,
    output DOUT_READY
  );
endinterface

// File: rtl/sdr_read_data_path.sv
// SDRAM read data path: CAS-latency token tracker, beat capture, FWFT FIFO.
// Ports: CLK, RESET_N (async low), RD_START/CAS_LAT/BURST_LEN from the
// command path, DQIN from the pins, host read port on the interface (DOUT,
// DOUT_VALID, DOUT_READY), status RD_DONE, BUSY, ERR_OVERLAP, OVERFLOW,
// FIFO_LEVEL. Define SDR_RD_REG_IN_EN to register DQIN before capture.
module sdr_read_data_path #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        CLK,
  input  logic                        RESET_N,
  input  logic                        RD_START,
  input  logic [1:0]                  CAS_LAT,
  input  logic [1:0]                  BURST_LEN,
  input  logic [DATA_WIDTH-1:0]       DQIN,
  sdr_read_data_path_if.master        host,
  output logic                        RD_DONE,
  output logic                        BUSY,
  output logic                        ERR_OVERLAP,
  output logic                        OVERFLOW,
  output logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [2:0]            tok_v;
  logic [3:0]            tok_bl [3];
  logic [3:0]            beat_cnt;
  logic [2:0]            space_cnt;
  logic [3:0]            bl_dec;
  logic                  start_ok;
  logic [1:0]            tap;
  logic                  load;
  logic [3:0]            load_bl;
  logic                  pend;
  logic                  capture;
  logic [DATA_WIDTH-1:0] cap_d;

  logic [AW:0]           wptr;
  logic [AW:0]           rptr;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic                  empty;
  logic                  full;
  logic                  pop;
  logic                  push;

  assign bl_dec   = 4'd1 << BURST_LEN;
  assign start_ok = RD_START && (space_cnt == 3'd0);
  assign capture  = (beat_cnt != 4'd0);

`ifdef SDR_RD_REG_IN_EN
  logic [DATA_WIDTH-1:0] dq_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) dq_q <= '0;
    else          dq_q <= DQIN;
  end

  assign cap_d = dq_q;
  // One extra stage of latency: load the counter one edge later.
  assign tap   = (CAS_LAT == 2'd3) ? 2'd2 : 2'd1;
`else
  assign cap_d = DQIN;
  assign tap   = (CAS_LAT == 2'd3) ? 2'd1 : 2'd0;
`endif

  always_comb begin
    load    = 1'b0;
    load_bl = 4'd0;
    pend    = 1'b0;
    unique case (tap)
      2'd0: begin
        load    = tok_v[0];
        load_bl = tok_bl[0];
        pend    = tok_v[0];
      end
      2'd1: begin
        load    = tok_v[1];
        load_bl = tok_bl[1];
        pend    = |tok_v[1:0];
      end
      default: begin
        load    = tok_v[2];
        load_bl = tok_bl[2];
        pend    = |tok_v;
      end
    endcase
  end

  assign BUSY = pend | capture;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tok_v  <= '0;
      tok_bl <= '{default: '0};
    end else begin
      tok_v     <= {tok_v[1:0], start_ok};
      tok_bl[0] <= bl_dec;
      tok_bl[1] <= tok_bl[0];
      tok_bl[2] <= tok_bl[1];
    end
  end

  // A reload on the last beat of the previous burst keeps the stream
  // gapless; that last beat still raises RD_DONE.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      beat_cnt <= 4'd0;
      RD_DONE  <= 1'b0;
    end else begin
      RD_DONE <= capture && (beat_cnt == 4'd1);
      if (load)         beat_cnt <= load_bl;
      else if (capture) beat_cnt <= beat_cnt - 4'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      space_cnt   <= 3'd0;
      ERR_OVERLAP <= 1'b0;
    end else begin
      ERR_OVERLAP <= RD_START && !start_ok;
      if (start_ok)               space_cnt <= 3'(bl_dec - 4'd1);
      else if (space_cnt != 3'd0) space_cnt <= space_cnt - 3'd1;
    end
  end

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop   = !empty && host.DOUT_READY;
  // At full a pop frees the head slot, which is the slot written here.
  assign push  = capture && (!full || pop);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wptr     <= '0;
      rptr     <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (capture && full && !pop) OVERFLOW <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wptr[AW-1:0]] <= cap_d;
  end

  assign host.DOUT       = empty ? '0 : mem[rptr[AW-1:0]];
  assign host.DOUT_VALID = !empty;
  assign FIFO_LEVEL      = wptr - rptr;
endmodule

// File: tb/tb_sdr_read_data_path.sv
// Testbench for sdr_read_data_path: scenario tasks plus randomized
// traffic compared against a beat-schedule reference model.
module tb_sdr_read_data_path;
  logic        CLK;
  logic        RESET_N;
  logic        RD_START;
  logic [1:0]  CAS_LAT;
  logic [1:0]  BURST_LEN;
  logic [31:0] DQIN;
  logic        RD_DONE;
  logic        BUSY;
  logic        ERR_OVERLAP;
  logic        OVERFLOW;
  logic [3:0]  FIFO_LEVEL;

  sdr_read_data_path_if #(.DATA_WIDTH(32)) bus ();

  sdr_read_data_path #(
    .DATA_WIDTH(32),
    .FIFO_DEPTH(8)
  ) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .RD_START   (RD_START),
    .CAS_LAT    (CAS_LAT),
    .BURST_LEN  (BURST_LEN),
    .DQIN       (DQIN),
    .host       (bus),
    .RD_DONE    (RD_DONE),
    .BUSY       (BUSY),
    .ERR_OVERLAP(ERR_OVERLAP),
    .OVERFLOW   (OVERFLOW),
    .FIFO_LEVEL (FIFO_LEVEL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: absolute edge index n, beat schedules keyed by edge.
  int          n = 0;
  int          d = 0;
  int          cl = 2;
  logic [31:0] q[$];
  bit          samp[int];
  bit          wr_at[int];
  logic [31:0] wdat[int];
  bit          done_edge[int];
  bit          have_last;
  int          last_e;
  int          last_bl;
  int          busy_end;
  bit          e_ovf, e_err, e_done, e_busy;

  function automatic logic [31:0] e_dout();
    return (q.size() != 0) ? q[0] : 32'h0;
  endfunction

  function automatic logic [3:0] e_level();
    return 4'(q.size());
  endfunction

  task automatic model_clear();
    q.delete();
    samp.delete();
    wr_at.delete();
    wdat.delete();
    done_edge.delete();
    have_last = 0;
    busy_end  = 0;
    e_ovf = 0; e_err = 0; e_done = 0; e_busy = 0;
  endtask

  task automatic tick(input bit st, input int blc,
                      input logic [31:0] dq, input bit rdy);
    bit fullm, popm;
    RD_START       = st;
    BURST_LEN      = 2'(blc);
    DQIN           = dq;
    bus.DOUT_READY = rdy;
    @(posedge CLK);
    n++;
    if (!RESET_N) begin
      model_clear();
    end else begin
      fullm = (q.size() == 8);
      popm  = (q.size() != 0) && rdy;
      if (samp.exists(n)) begin
        wr_at[n+d] = 1;
        wdat[n+d]  = dq;
      end
      if (popm) void'(q.pop_front());
      if (wr_at.exists(n)) begin
        if (!fullm || popm) q.push_back(wdat[n]);
        else                e_ovf = 1;
      end
      e_err = 0;
      if (st) begin
        if (!have_last || (n - last_e) >= last_bl) begin
          have_last = 1;
          last_e    = n;
          last_bl   = 1 << blc;
          for (int k = 0; k < last_bl; k++) samp[n+cl+k] = 1;
          busy_end = n + cl + d + last_bl - 1;
          done_edge[busy_end] = 1;
        end else begin
          e_err = 1;
        end
      end
      e_done = done_edge.exists(n);
      e_busy = have_last && (n < busy_end);
    end
    @(negedge CLK);
  endtask

  task automatic set_cl(input int c);
    cl      = c;
    CAS_LAT = 2'(c);
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    RD_START = 0; BURST_LEN = 0; DQIN = 0; bus.DOUT_READY = 0;
    set_cl(2);
    model_clear();
    tick(0, 0, 32'h0, 0);
    tick(0, 0, 32'h0, 0);
    checks++; if (bus.DOUT !== 32'h0) begin errors++; $display("FAIL rst_dout got %h exp 0", bus.DOUT); end
    checks++; if (bus.DOUT_VALID !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", bus.DOUT_VALID); end
    checks++; if (RD_DONE !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", RD_DONE); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", BUSY); end
    checks++; if (ERR_OVERLAP !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", ERR_OVERLAP); end
    checks++; if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b exp 0", OVERFLOW); end
    checks++; if (FIFO_LEVEL !== 4'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", FIFO_LEVEL); end
    RESET_N = 1'b1;
    for (int i = 0; i < 3; i++) tick(0, 0, $urandom, 1);
  endtask

  task automatic test_cl2_bl4();
    logic [31:0] got[$];
    logic [31:0] exp4 [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    logic [31:0] dq;
    int first_v = -1;
    int dones = 0;
    set_cl(2);
    for (int i = 0; i < 12; i++) begin
      dq = (i >= 2 && i <= 5) ? 32'(32'h11 * (i - 1)) : $urandom;
      tick(i == 0, 2, dq, 1);
      checks++; if (bus.DOUT_VALID !== (q.size() != 0)) begin errors++; $display("FAIL cl2_valid i=%0d got %b exp %b", i, bus.DOUT_VALID, q.size() != 0); end
      checks++; if (bus.DOUT !== e_dout()) begin errors++; $display("FAIL cl2_dout i=%0d got %h exp %h", i, bus.DOUT, e_dout()); end
      checks++; if (RD_DONE !== e_done) begin errors++; $display("FAIL cl2_done i=%0d got %b exp %b", i, RD_DONE, e_done); end
      checks++; if (BUSY !== e_busy) begin errors++; $display("FAIL cl2_busy i=%0d got %b exp %b", i, BUSY, e_busy); end
      if (bus.DOUT_VALID === 1'b1) begin
        got.push_back(bus.DOUT);
        if (first_v < 0) first_v = i;
      end
      if (RD_DONE === 1'b1) dones++;
    end
    checks++; if (first_v != 2 + d) begin errors++; $display("FAIL cl2_first_valid got %0d exp %0d", first_v, 2 + d); end
    checks++; if (dones != 1) begin errors++; $display("FAIL cl2_done_count got %0d exp 1", dones); end
    checks++; if (got.size() != 4) begin errors++; $display("FAIL cl2_beats got %0d exp 4", got.size()); end
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      checks++; if (got[k] !== exp4[k]) begin errors++; $display("FAIL cl2_seq k=%0d got %h exp %h", k, got[k], exp4[k]); end
    end
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    int errs = 0;
    int vcyc = 0;
    set_cl(3);
    for (int i = 0; i < 14; i++) begin
      tick(i == 0 || i == 2, 1, $urandom, 1);
      checks++; if (ERR_OVERLAP !== e_err) begin errors++; $display("FAIL b2b_err i=%0d got %b exp %b", i, ERR_OVERLAP, e_err); end
      checks++; if (RD_DONE !== e_done) begin errors++; $display("FAIL b2b_done i=%0d got %b exp %b", i, RD_DONE, e_done); end
      checks++; if (bus.DOUT !== e_dout()) begin errors++; $display("FAIL b2b_dout i=%0d got %h exp %h", i, bus.DOUT, e_dout()); end
      if (RD_DONE === 1'b1) dones++;
      if (ERR_OVERLAP === 1'b1) errs++;
      if (bus.DOUT_VALID === 1'b1) vcyc++;
    end
    checks++; if (dones != 2) begin errors++; $display("FAIL b2b_done_count got %0d exp 2", dones); end
    checks++; if (errs != 0) begin errors++; $display("FAIL b2b_err_count got %0d exp 0", errs); end
    checks++; if (vcyc != 4) begin errors++; $display("FAIL b2b_beats got %0d exp 4", vcyc); end
  endtask

  task automatic test_overlap();
    int dones = 0;
    int vcyc = 0;
    set_cl(2);
    for (int i = 0; i < 18; i++) begin
      tick(i == 0 || i == 3, 3, $urandom, 1);
      checks++; if (ERR_OVERLAP !== e_err) begin errors++; $display("FAIL ovl_err i=%0d got %b exp %b", i, ERR_OVERLAP, e_err); end
      checks++; if (BUSY !== e_busy) begin errors++; $display("FAIL ovl_busy i=%0d got %b exp %b", i, BUSY, e_busy); end
      checks++; if (FIFO_LEVEL !== e_level()) begin errors++; $display("FAIL ovl_level i=%0d got %0d exp %0d", i, FIFO_LEVEL, e_level()); end
      if (i == 3) begin
        checks++; if (ERR_OVERLAP !== 1'b1) begin errors++; $display("FAIL ovl_pulse got %b exp 1", ERR_OVERLAP); end
      end
      if (RD_DONE === 1'b1) dones++;
      if (bus.DOUT_VALID === 1'b1) vcyc++;
    end
    checks++; if (dones != 1) begin errors++; $display("FAIL ovl_done_count got %0d exp 1", dones); end
    checks++; if (vcyc != 8) begin errors++; $display("FAIL ovl_beats got %0d exp 8", vcyc); end
  endtask

  task automatic test_overflow();
    int t0;
    set_cl(2);
    t0 = cl + d;
    for (int i = 0; i < t0 + 18; i++) begin
      tick(i == 0 || i == 8, 3, $urandom, 0);
      checks++; if (FIFO_LEVEL !== e_level()) begin errors++; $display("FAIL ovf_level i=%0d got %0d exp %0d", i, FIFO_LEVEL, e_level()); end
      checks++; if (OVERFLOW !== e_ovf) begin errors++; $display("FAIL ovf_flag i=%0d got %b exp %b", i, OVERFLOW, e_ovf); end
      checks++; if (bus.DOUT !== e_dout()) begin errors++; $display("FAIL ovf_dout i=%0d got %h exp %h", i, bus.DOUT, e_dout()); end
      if (i == t0 + 7) begin
        checks++; if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL ovf_early got %b exp 0", OVERFLOW); end
      end
      if (i == t0 + 8) begin
        checks++; if (OVERFLOW !== 1'b1) begin errors++; $display("FAIL ovf_9th got %b exp 1", OVERFLOW); end
      end
    end
    checks++; if (FIFO_LEVEL !== 4'd8) begin errors++; $display("FAIL ovf_full got %0d exp 8", FIFO_LEVEL); end
    for (int i = 0; i < t0 + 18; i++) begin
      tick(i == 0, 3, $urandom, i >= t0);
      checks++; if (FIFO_LEVEL !== e_level()) begin errors++; $display("FAIL popfull_level i=%0d got %0d exp %0d", i, FIFO_LEVEL, e_level()); end
      checks++; if (bus.DOUT !== e_dout()) begin errors++; $display("FAIL popfull_dout i=%0d got %h exp %h", i, bus.DOUT, e_dout()); end
      if (i >= t0 && i <= t0 + 7) begin
        checks++; if (FIFO_LEVEL !== 4'd8) begin errors++; $display("FAIL popfull_hold i=%0d got %0d exp 8", i, FIFO_LEVEL); end
      end
    end
    checks++; if (FIFO_LEVEL !== 4'd0) begin errors++; $display("FAIL popfull_drain got %0d exp 0", FIFO_LEVEL); end
  endtask

  task automatic test_reset_mid();
    set_cl(2);
    for (int i = 0; i <= cl + 1; i++) tick(i == 0, 3, $urandom, 0);
    RESET_N = 1'b0;
    #1;
    model_clear();
    checks++; if (bus.DOUT !== 32'h0) begin errors++; $display("FAIL mid_dout got %h exp 0", bus.DOUT); end
    checks++; if (bus.DOUT_VALID !== 1'b0) begin errors++; $display("FAIL mid_valid got %b exp 0", bus.DOUT_VALID); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL mid_busy got %b exp 0", BUSY); end
    checks++; if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL mid_ovf got %b exp 0", OVERFLOW); end
    checks++; if (FIFO_LEVEL !== 4'd0) begin errors++; $display("FAIL mid_level got %0d exp 0", FIFO_LEVEL); end
    checks++; if (RD_DONE !== 1'b0) begin errors++; $display("FAIL mid_done got %b exp 0", RD_DONE); end
    tick(0, 0, $urandom, 0);
    tick(0, 0, $urandom, 0);
    RESET_N = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick(0, 0, $urandom, 0);
      checks++; if (FIFO_LEVEL !== 4'd0) begin errors++; $display("FAIL mid_after_level i=%0d got %0d exp 0", i, FIFO_LEVEL); end
      checks++; if (RD_DONE !== 1'b0) begin errors++; $display("FAIL mid_after_done i=%0d got %b exp 0", i, RD_DONE); end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 14; i++) tick(0, 0, $urandom, 1);
      set_cl($urandom_range(2, 3));
      for (int i = 0; i < 120; i++) begin
        tick($urandom_range(0, 3) == 0, $urandom_range(0, 3), $urandom,
             $urandom_range(0, 3) != 0);
        checks++; if (bus.DOUT_VALID !== (q.size() != 0)) begin errors++; $display("FAIL rnd_valid n=%0d got %b exp %b", n, bus.DOUT_VALID, q.size() != 0); end
        checks++; if (bus.DOUT !== e_dout()) begin errors++; $display("FAIL rnd_dout n=%0d got %h exp %h", n, bus.DOUT, e_dout()); end
        checks++; if (RD_DONE !== e_done) begin errors++; $display("FAIL rnd_done n=%0d got %b exp %b", n, RD_DONE, e_done); end
        checks++; if (BUSY !== e_busy) begin errors++; $display("FAIL rnd_busy n=%0d got %b exp %b", n, BUSY, e_busy); end
        checks++; if (ERR_OVERLAP !== e_err) begin errors++; $display("FAIL rnd_err n=%0d got %b exp %b", n, ERR_OVERLAP, e_err); end
        checks++; if (OVERFLOW !== e_ovf) begin errors++; $display("FAIL rnd_ovf n=%0d got %b exp %b", n, OVERFLOW, e_ovf); end
        checks++; if (FIFO_LEVEL !== e_level()) begin errors++; $display("FAIL rnd_level n=%0d got %0d exp %0d", n, FIFO_LEVEL, e_level()); end
      end
    end
  endtask

  initial begin
`ifdef SDR_RD_REG_IN_EN
    d = 1;
`else
    d = 0;
`endif
    test_reset();
    test_cl2_bl4();
    test_back_to_back();
    test_overlap();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
